ef_tmr32_wb_seq: RTL and testbench

EF_TMR32_WB_SEQ -- requirements
Module: ef_tmr32_wb_seq

---
 rtl/ef_tmr32_wb_seq.sv | 157 +++++++++++++++
 tb/tb_ef_tmr32_wb_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ef_tmr32_wb_seq.sv
// ef_tmr32_wb_seq: Wishbone master that programs a 32-bit timer profile, dwells, and supports abort/timeout
module ef_tmr32_wb_seq #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   reload,
    input  logic [31:0]   pr,
    input  logic [2:0]    cfg,
    input  logic [31:0]   cmpx,
    input  logic [31:0]   cmpy,
    input  logic [11:0]   pwm0cfg,
    input  logic [11:0]   pwm1cfg,
    input  logic [7:0]    pwmdt,
    input  logic [4:0]    ctrl,
    input  logic [23:0]   dwell,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [3:0]    sel_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    input  logic          ack_i
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_DWELL, S_ABRT} state_t;
    state_t r_state, w_next;
    logic [3:0]  r_idx;
    logic [23:0] r_dw;
    logic [15:0] r_to;
    logic        r_abt, r_busy, r_done, r_aborted, r_err;
    logic [31:0] r_reload, r_pr, r_cmpx, r_cmpy;
    logic [2:0]  r_cfg;
    logic [11:0] r_pwm0, r_pwm1;
    logic [7:0]  r_pwmdt;
    logic [4:0]  r_ctrl;
    logic [23:0] r_dwell;
    logic        w_abt, w_last, w_bus, w_done, w_abd, w_tmo;
    logic [7:0]  w_a;
    logic [31:0] w_d;
    assign w_abt  = r_abt | abort;
    assign w_last = r_to == 16'(TIMEOUT - 1);
    assign w_bus  = r_state == S_WR || r_state == S_ABRT;
    // next state plus completion events; an abort pending at ack always passes through GAP first
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_abd  = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = start ? S_WR : S_IDLE;
            S_WR: begin
                if (ack_i) begin
                    if (w_abt || r_idx != 4'd9) w_next = S_GAP;
                    else if (r_dwell == 24'd0) begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end else w_next = S_DWELL;
                end else if (w_last) begin
                    w_next = S_IDLE;
                    w_tmo  = 1'b1;
                end
            end
            S_GAP:   w_next = w_abt ? S_ABRT : S_WR;
            S_DWELL: begin
                if (abort) w_next = S_ABRT;
                else if (r_dw == r_dwell - 24'd1) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_ABRT: begin
                if (ack_i) begin
                    w_next = S_IDLE;
                    w_abd  = 1'b1;
                end else if (w_last) begin
                    w_next = S_IDLE;
                    w_tmo  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
    // register write list; the abort write uses the 0x14/0 default
    always_comb begin
        w_a = 8'h14;
        w_d = 32'h0;
        if (r_state == S_WR)
            case (r_idx)
                4'd1: begin w_a = 8'h04; w_d = r_reload; end
                4'd2: begin w_a = 8'h08; w_d = r_pr; end
                4'd3: begin w_a = 8'h18; w_d = 32'(r_cfg); end
                4'd4: begin w_a = 8'h0C; w_d = r_cmpx; end
                4'd5: begin w_a = 8'h10; w_d = r_cmpy; end
                4'd6: begin w_a = 8'h1C; w_d = 32'(r_pwm0); end
                4'd7: begin w_a = 8'h20; w_d = 32'(r_pwm1); end
                4'd8: begin w_a = 8'h24; w_d = 32'(r_pwmdt); end
                4'd9: begin w_a = 8'h14; w_d = 32'(r_ctrl); end
                default: ;
            endcase
    end
    assign cyc_o   = w_bus;
    assign stb_o   = w_bus;
    assign we_o    = w_bus;
    assign sel_o   = {4{w_bus}};
    assign adr_o   = w_bus ? AW'(w_a) : '0;
    assign dat_o   = w_bus ? w_d : 32'h0;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign err     = r_err;
    // state, counters, latched profile and status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_dw      <= 24'd0;
            r_to      <= 16'd0;
            r_abt     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= w_done;
            r_aborted <= w_abd;
            r_abt     <= r_state != S_IDLE && r_state != S_ABRT && w_abt;
            r_to      <= (w_bus && w_next == r_state) ? r_to + 16'd1 : 16'd0;
            r_dw      <= (r_state == S_DWELL && w_next == S_DWELL) ? r_dw + 24'd1 : 24'd0;
            if (r_state == S_GAP && w_next == S_WR) r_idx <= r_idx + 4'd1;
            if (r_state == S_IDLE && start) begin
                r_idx    <= 4'd0;
                r_err    <= 1'b0;
                r_busy   <= 1'b1;
                r_reload <= reload;
                r_pr     <= pr;
                r_cfg    <= cfg;
                r_cmpx   <= cmpx;
                r_cmpy   <= cmpy;
                r_pwm0   <= pwm0cfg;
                r_pwm1   <= pwm1cfg;
                r_pwmdt  <= pwmdt;
                r_ctrl   <= ctrl;
                r_dwell  <= dwell;
            end
            if (w_tmo) r_err <= 1'b1;
            if (w_done || w_abd || w_tmo) r_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ef_tmr32_wb_seq.sv
// tb_ef_tmr32_wb_seq: directed and randomized checks of the profile sequencer against a write-queue model
module tb_ef_tmr32_wb_seq;
    localparam int AW = 16;
    localparam int TO = 16;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1, start = 1'b0, abort = 1'b0, ack_i = 1'b0;
    logic [31:0] reload = '0, pr = '0, cmpx = '0, cmpy = '0;
    logic [2:0]  cfg = '0;
    logic [11:0] pwm0cfg = '0, pwm1cfg = '0;
    logic [7:0]  pwmdt = '0;
    logic [4:0]  ctrl = '0;
    logic [23:0] dwell = '0;
    logic busy, done, aborted, err, cyc_o, stb_o, we_o;
    logic [3:0] sel_o;
    logic [AW-1:0] adr_o;
    logic [31:0] dat_o;
    always #5 clk_i = ~clk_i;
    ef_tmr32_wb_seq #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .abort(abort),
        .reload(reload), .pr(pr), .cfg(cfg), .cmpx(cmpx), .cmpy(cmpy),
        .pwm0cfg(pwm0cfg), .pwm1cfg(pwm1cfg), .pwmdt(pwmdt), .ctrl(ctrl), .dwell(dwell),
        .busy(busy), .done(done), .aborted(aborted), .err(err),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i)
    );
    int n_run = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask
    // model: phase 0 idle, 1 strobe up, 2 gap, 3 dwell; q holds the writes still owed, front = on the bus
    int m_ph = 0, m_wait = 0, m_left = 0;
    logic [63:0] q[$];
    bit m_ab = 0, m_req = 0, m_busy = 0, m_done = 0, m_abd = 0, m_err = 0;
    logic [23:0] m_dw = '0;
    task automatic model_update();
        if (rst_i) begin
            m_ph = 0; q.delete(); m_ab = 0; m_req = 0; m_busy = 0;
            m_done = 0; m_abd = 0; m_err = 0; m_wait = 0; m_left = 0;
        end else begin
            m_done = 0;
            m_abd  = 0;
            case (m_ph)
                0: if (start) begin
                    q.delete();
                    q.push_back({32'h14, 32'h0});
                    q.push_back({32'h04, reload});
                    q.push_back({32'h08, pr});
                    q.push_back({32'h18, 32'(cfg)});
                    q.push_back({32'h0C, cmpx});
                    q.push_back({32'h10, cmpy});
                    q.push_back({32'h1C, 32'(pwm0cfg)});
                    q.push_back({32'h20, 32'(pwm1cfg)});
                    q.push_back({32'h24, 32'(pwmdt)});
                    q.push_back({32'h14, 32'(ctrl)});
                    m_dw = dwell; m_err = 0; m_busy = 1; m_ph = 1; m_wait = 0; m_req = 0; m_ab = 0;
                end
                1: begin
                    if (abort && !m_ab) m_req = 1;
                    if (ack_i) begin
                        q.delete(0);
                        if (m_ab) begin m_ph = 0; m_busy = 0; m_abd = 1; end
                        else if (m_req || q.size() != 0) m_ph = 2;
                        else if (m_dw == 0) begin m_ph = 0; m_busy = 0; m_done = 1; end
                        else begin m_ph = 3; m_left = int'(m_dw); end
                    end else begin
                        m_wait++;
                        if (m_wait == TO) begin m_ph = 0; m_busy = 0; m_err = 1; end
                    end
                end
                2: begin
                    m_wait = 0;
                    if (abort || m_req) begin q.delete(); q.push_back({32'h14, 32'h0}); m_ab = 1; end
                    m_ph = 1;
                end
                default: begin
                    if (abort) begin
                        q.delete(); q.push_back({32'h14, 32'h0}); m_ab = 1; m_wait = 0; m_ph = 1;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = 0; m_busy = 0; m_done = 1; end
                    end
                end
            endcase
        end
    endtask
    task automatic compare();
        bit b;
        logic [63:0] e;
        b = m_ph == 1 && q.size() != 0;
        e = b ? q[0] : 64'h0;
        chk("cyc_o", 64'(cyc_o), 64'(b));
        chk("stb_o", 64'(stb_o), 64'(b));
        chk("we_o", 64'(we_o), 64'(b));
        chk("sel_o", 64'(sel_o), 64'({4{b}}));
        chk("adr_o", 64'(adr_o), {32'h0, e[63:32]});
        chk("dat_o", 64'(dat_o), {32'h0, e[31:0]});
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("aborted", 64'(aborted), 64'(m_abd));
        chk("err", 64'(err), 64'(m_err));
    endtask
    int cy = 0;
    task automatic step();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare();
        cy++;
    endtask
    int rises[$];
    logic [63:0] wr[$];
    int done_c, ab_n, busy_n, stb_n;
    logic e1;
    logic [63:0] zpost;
    bit pstb, pack;
    task automatic run(input int n, input int ab_c, input int st2_c, input int rst_c, input bit noack);
        rises.delete(); wr.delete();
        done_c = -1; ab_n = 0; busy_n = 0; stb_n = 0; cy = 0; pstb = 0; pack = 0; e1 = 1'bx; zpost = '1;
        for (int k = 0; k < n; k++) begin
            start = cy == 0 || cy == st2_c;
            abort = cy == ab_c;
            rst_i = cy == rst_c;
            ack_i = !noack && stb_o && pstb && !pack;
            pack = ack_i;
            pstb = stb_o;
            step();
            if (stb_o && !pstb) begin rises.push_back(cy); wr.push_back({32'(adr_o), dat_o}); end
            if (done) done_c = cy;
            if (aborted) ab_n++;
            if (busy) busy_n++;
            if (stb_o) stb_n++;
            if (cy == 1) e1 = err;
            if (cy == rst_c + 1)
                zpost = {cyc_o, stb_o, we_o, sel_o, 32'(adr_o), dat_o, busy, done, aborted, err};
        end
        start = 0; abort = 0; rst_i = 0; ack_i = 0;
    endtask
    task automatic nominal_checks(input string tag);
        chk({tag, "_nwr"}, 64'(rises.size()), 64'd10);
        if (rises.size() == 10) begin
            chk({tag, "_rise0"}, 64'(rises[0]), 64'd1);
            chk({tag, "_rise9"}, 64'(rises[9]), 64'd28);
        end
        chk({tag, "_donecy"}, 64'(done_c), 64'd35);
    endtask
    int lat = 0, rw = 0;
    initial begin
        repeat (3) step();
        rst_i = 0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reload = 32'd10; pr = 32'd4; cfg = 3'b111; ctrl = 5'b00001; dwell = 24'd5;
        cmpx = 32'h55; cmpy = 32'hAA; pwm0cfg = 12'h123; pwm1cfg = 12'h456; pwmdt = 8'h7;
        run(40, -1, -1, -1, 0);
        nominal_checks("nom");
        if (wr.size() == 10) begin
            chk("nom_w0", wr[0], {32'h14, 32'h0});
            chk("nom_w1", wr[1], {32'h04, 32'd10});
            chk("nom_w2", wr[2], {32'h08, 32'd4});
            chk("nom_w3", wr[3], {32'h18, 32'd7});
            chk("nom_w9", wr[9], {32'h14, 32'd1});
        end
        dwell = 24'd0;
        run(35, -1, -1, -1, 0);
        chk("dw0_donecy", 64'(done_c), 64'd30);
        chk("dw0_busycycles", 64'(busy_n), 64'd29);
        chk("dw0_nwr", 64'(rises.size()), 64'd10);
        dwell = 24'd5;
        run(40, 10, -1, -1, 0);
        chk("ab_nwr", 64'(rises.size()), 64'd5);
        if (wr.size() == 5) chk("ab_write", wr[4], {32'h14, 32'h0});
        chk("ab_pulse", 64'(ab_n), 64'd1);
        chk("ab_nodone", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
        run(30, -1, -1, -1, 1);
        chk("to_stbcycles", 64'(stb_n), 64'd16);
        chk("to_err", 64'(err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        run(20, -1, -1, -1, 1);
        chk("to_errclr", 64'(e1), 64'd0);
        run(40, -1, 5, -1, 0);
        nominal_checks("st2");
        run(34, -1, -1, 32, 0);
        chk("rst_dwell_zero", zpost, 64'd0);
        run(40, -1, -1, -1, 0);
        nominal_checks("post_rst");
        pstb = 0;
        for (int k = 0; k < 4000; k++) begin
            rst_i = $urandom_range(299) == 0;
            start = $urandom_range(19) == 0;
            abort = $urandom_range(29) == 0;
            reload = $urandom; pr = $urandom; cmpx = $urandom; cmpy = $urandom;
            cfg = 3'($urandom); ctrl = 5'($urandom); pwmdt = 8'($urandom);
            pwm0cfg = 12'($urandom); pwm1cfg = 12'($urandom);
            dwell = 24'($urandom_range(6));
            if (stb_o) begin
                if (!pstb) begin rw = 0; lat = $urandom_range(9) == 0 ? 99 : $urandom_range(3); end
                ack_i = rw >= lat;
                rw++;
            end else ack_i = $urandom_range(7) == 0;
            pstb = stb_o;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
